// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the GeMIPS MEM stage: memory op codes, FSM states
// and small op-decoding helpers used by mem_ctrl and mem_align.
package mem_defs;

    localparam logic [7:0] MEM_NOP = 8'h00;
    localparam logic [7:0] MEM_LB  = 8'h01;
    localparam logic [7:0] MEM_LBU = 8'h02;
    localparam logic [7:0] MEM_LH  = 8'h03;
    localparam logic [7:0] MEM_LHU = 8'h04;
    localparam logic [7:0] MEM_LW  = 8'h05;
    localparam logic [7:0] MEM_SB  = 8'h06;
    localparam logic [7:0] MEM_SH  = 8'h07;
    localparam logic [7:0] MEM_SW  = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } size_e;

    function automatic size_e op_size(input logic [7:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
            MEM_LW, MEM_SW:          return SZ_WORD;
            default:                 return SZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [7:0] op);
        return (op >= MEM_LB) && (op <= MEM_LW);
    endfunction

    function automatic logic op_is_store(input logic [7:0] op);
        return (op >= MEM_SB) && (op <= MEM_SW);
    endfunction

endpackage

// File: rtl/mem_ctrl_align.sv
// Combinational lane logic: byte enables, store-data replication, misalignment
// detection and load-data lane selection with sign/zero extension.
module mem_align
    import mem_defs::*;
(
    input  logic [7:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  be_n_o,
    output logic [31:0] st_data_o,
    output logic        misalign_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    size_e       size;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = raw_i[8*gi +: 8];
    end

    assign size     = op_size(op_i);
    assign byte_sel = lane[addr_lo_i];
    assign half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

    always_comb begin
        be_n_o     = 4'hF;
        st_data_o  = 32'h0;
        misalign_o = 1'b0;
        ld_data_o  = raw_i;
        case (size)
            SZ_BYTE: begin
                be_n_o    = ~(4'b0001 << addr_lo_i);
                st_data_o = {4{st_data_i[7:0]}};
                ld_data_o = (op_i == MEM_LB) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h0, byte_sel};
            end
            SZ_HALF: begin
                misalign_o = addr_lo_i[0];
                be_n_o     = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                st_data_o  = {2{st_data_i[15:0]}};
                ld_data_o  = (op_i == MEM_LH) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'h0, half_sel};
            end
            SZ_WORD: begin
                misalign_o = |addr_lo_i;
                be_n_o     = 4'h0;
                st_data_o  = st_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Multi-cycle MEM stage driving an asynchronous SRAM with WAIT_CYCLES extra
// access cycles; stalls the pipeline for the whole access.
module mem_ctrl
    import mem_defs::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int RAM_AW      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [7:0]        mem_op,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    output logic              we_o,
    output logic [4:0]        waddr_o,
    output logic [31:0]       wdata_o,
    output logic              stall_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [31:0]       bad_vaddr_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    input  logic [31:0]       ram_data_i,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [3:0]        ram_be_n
);

    // A zero-wait configuration still needs a 1-bit counter.
    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          is_load, is_store, is_mem;
    logic [3:0]    be_n;
    logic [31:0]   st_data;
    logic          misalign;
    logic [31:0]   ld_data;

    assign is_load  = op_is_load(mem_op);
    assign is_store = op_is_store(mem_op);
    assign is_mem   = is_load | is_store;

    mem_align u_align (
        .op_i       (mem_op),
        .addr_lo_i  (mem_addr_i[1:0]),
        .st_data_i  (mem_data_i),
        .raw_i      (rdata_q),
        .be_n_o     (be_n),
        .st_data_o  (st_data),
        .misalign_o (misalign),
        .ld_data_o  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        we_o        = 1'b0;
        waddr_o     = waddr_i;
        wdata_o     = wdata_i;
        stall_o     = 1'b0;
        adel_o      = 1'b0;
        ades_o      = 1'b0;
        bad_vaddr_o = 32'h0;
        ram_ce_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_be_n    = 4'hF;
        ram_addr_o  = mem_addr_i[RAM_AW+1:2];
        ram_data_o  = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (!is_mem) begin
                    we_o = we_i;
                end else if (misalign) begin
                    adel_o      = is_load;
                    ades_o      = is_store;
                    bad_vaddr_o = mem_addr_i;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                stall_o    = 1'b1;
                ram_ce_n   = 1'b0;
                ram_oe_n   = ~is_load;
                ram_we_n   = ~is_store;
                ram_be_n   = be_n;
                ram_data_o = is_store ? st_data : 32'h0;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (is_load) begin
                        rdata_d = ram_data_i;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (is_load) begin
                    we_o    = we_i;
                    wdata_o = ld_data;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset masks every output in the same cycle so an in-flight write is cut off immediately.
        if (rst) begin
            we_o        = 1'b0;
            waddr_o     = 5'h0;
            wdata_o     = 32'h0;
            stall_o     = 1'b0;
            adel_o      = 1'b0;
            ades_o      = 1'b0;
            bad_vaddr_o = 32'h0;
            ram_ce_n    = 1'b1;
            ram_oe_n    = 1'b1;
            ram_we_n    = 1'b1;
            ram_be_n    = 4'hF;
            ram_addr_o  = '0;
            ram_data_o  = 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: instance 0 (WAIT_CYCLES=1) runs a vector table, instance 1
// (WAIT_CYCLES=3) runs back-to-back and reset-abort sequences against a small SRAM.
module tb_mem_ctrl;
    import mem_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        we_i        [2];
    logic [4:0]  waddr_i     [2];
    logic [31:0] wdata_i     [2];
    logic [7:0]  mem_op      [2];
    logic [31:0] mem_addr_i  [2];
    logic [31:0] mem_data_i  [2];
    logic        we_o        [2];
    logic [4:0]  waddr_o     [2];
    logic [31:0] wdata_o     [2];
    logic        stall_o     [2];
    logic        adel_o      [2];
    logic        ades_o      [2];
    logic [31:0] bad_vaddr_o [2];
    logic [19:0] ram_addr_o  [2];
    logic [31:0] ram_data_o  [2];
    logic        ram_ce_n    [2];
    logic        ram_oe_n    [2];
    logic        ram_we_n    [2];
    logic [3:0]  ram_be_n    [2];

    logic [31:0] rd0;
    logic [31:0] sram1 [16];
    wire  [31:0] rd1 = sram1[ram_addr_o[1][3:0]];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_ctrl #(
            .WAIT_CYCLES (gi == 0 ? 1 : 3),
            .RAM_AW      (20)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .we_i        (we_i[gi]),
            .waddr_i     (waddr_i[gi]),
            .wdata_i     (wdata_i[gi]),
            .mem_op      (mem_op[gi]),
            .mem_addr_i  (mem_addr_i[gi]),
            .mem_data_i  (mem_data_i[gi]),
            .we_o        (we_o[gi]),
            .waddr_o     (waddr_o[gi]),
            .wdata_o     (wdata_o[gi]),
            .stall_o     (stall_o[gi]),
            .adel_o      (adel_o[gi]),
            .ades_o      (ades_o[gi]),
            .bad_vaddr_o (bad_vaddr_o[gi]),
            .ram_addr_o  (ram_addr_o[gi]),
            .ram_data_o  (ram_data_o[gi]),
            .ram_data_i  (gi == 0 ? rd0 : rd1),
            .ram_ce_n    (ram_ce_n[gi]),
            .ram_oe_n    (ram_oe_n[gi]),
            .ram_we_n    (ram_we_n[gi]),
            .ram_be_n    (ram_be_n[gi])
        );
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!ram_ce_n[1] && !ram_we_n[1]) begin
            for (int b = 0; b < 4; b++) begin
                if (!ram_be_n[1][b]) sram1[ram_addr_o[1][3:0]][8*b +: 8] <= ram_data_o[1][8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdo;
        logic [1:0]  exp_exc;
        int          exp_stall;
    } vec_t;

    vec_t sb [$];
    vec_t vecs [17];

    function automatic vec_t mk(logic [7:0] op, logic [31:0] addr, logic [31:0] sdata,
                                logic [31:0] rdata, logic we, logic [4:0] waddr,
                                logic [31:0] wdata, logic exp_we, logic [31:0] exp_wdata,
                                logic [3:0] exp_be, logic [31:0] exp_rdo, logic [1:0] exp_exc,
                                int exp_stall);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.exp_we = exp_we; v.exp_wdata = exp_wdata; v.exp_be = exp_be;
        v.exp_rdo = exp_rdo; v.exp_exc = exp_exc; v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [131:0] pack_outs(input int k);
        return {we_o[k], waddr_o[k], wdata_o[k], stall_o[k], adel_o[k], ades_o[k],
                bad_vaddr_o[k], ram_ce_n[k], ram_oe_n[k], ram_we_n[k], ram_be_n[k],
                ram_addr_o[k], ram_data_o[k]};
    endfunction

    task automatic set_nop(input int k);
        mem_op[k] = MEM_NOP; we_i[k] = 1'b0; waddr_i[k] = 5'h0; wdata_i[k] = 32'h0;
        mem_addr_i[k] = 32'h0; mem_data_i[k] = 32'h0;
    endtask

    // Drives one op (entered just after a rising edge, in IDLE) and checks it when stall drops.
    task automatic run_op(input int k, input vec_t v);
        int          stall_n, ce_n, oe_n, wen_n, exp_acc;
        logic [3:0]  be_s;
        logic [31:0] rdo_s, o_wd, o_bad;
        logic [19:0] ra_s;
        logic        held_bad, done, o_we, o_adel, o_ades, is_ld, is_st;
        logic [4:0]  o_wa;
        vec_t        e;
        string       tag;
        mem_op[k] = v.op; mem_addr_i[k] = v.addr; mem_data_i[k] = v.sdata;
        we_i[k] = v.we; waddr_i[k] = v.waddr; wdata_i[k] = v.wdata;
        if (k == 0) rd0 = v.rdata;
        sb.push_back(v);
        stall_n = 0; ce_n = 0; oe_n = 0; wen_n = 0;
        be_s = 4'hF; rdo_s = 32'h0; ra_s = 20'h0; held_bad = 1'b0; done = 1'b0;
        o_we = 1'b0; o_wa = 5'h0; o_wd = 32'h0; o_bad = 32'h0; o_adel = 1'b0; o_ades = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!ram_ce_n[k]) begin
                if (ce_n == 0) begin
                    be_s = ram_be_n[k]; rdo_s = ram_data_o[k]; ra_s = ram_addr_o[k];
                end else if (ram_be_n[k] != be_s || ram_data_o[k] != rdo_s || ram_addr_o[k] != ra_s) begin
                    held_bad = 1'b1;
                end
                ce_n++;
                if (!ram_oe_n[k]) oe_n++;
                if (!ram_we_n[k]) wen_n++;
            end else if (!ram_oe_n[k] || !ram_we_n[k]) begin
                held_bad = 1'b1;
            end
            if (!stall_o[k]) begin
                o_we = we_o[k]; o_wa = waddr_o[k]; o_wd = wdata_o[k];
                o_bad = bad_vaddr_o[k]; o_adel = adel_o[k]; o_ades = ades_o[k];
                done = 1'b1;
                break;
            end
            stall_n++;
        end
        tag = $sformatf("k%0d op%02h a%08h", k, v.op, v.addr);
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout stall_o still high after 40 cycles", tag);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            is_ld = e.op inside {[MEM_LB:MEM_LW]};
            is_st = e.op inside {[MEM_SB:MEM_SW]};
            exp_acc = (e.exp_stall > 0) ? e.exp_stall - 1 : 0;
            chk({tag, " stall_cycles"}, stall_n, e.exp_stall);
            chk({tag, " ce_cycles"}, ce_n, exp_acc);
            chk({tag, " oe_cycles"}, oe_n, is_ld ? exp_acc : 0);
            chk({tag, " we_n_cycles"}, wen_n, is_st ? exp_acc : 0);
            chk({tag, " held_stable"}, held_bad, 1'b0);
            chk({tag, " ram_be_n"}, be_s, e.exp_be);
            if (ce_n > 0) chk({tag, " ram_addr"}, ra_s, e.addr[21:2]);
            if (is_st) chk({tag, " ram_data_o"}, rdo_s, e.exp_rdo);
            chk({tag, " exc"}, {o_adel, o_ades}, e.exp_exc);
            if (e.exp_exc != 2'b00) chk({tag, " bad_vaddr"}, o_bad, e.addr);
            chk({tag, " we_o"}, o_we, e.exp_we);
            if (e.exp_we) begin
                chk({tag, " wdata_o"}, o_wd, e.exp_wdata);
                chk({tag, " waddr_o"}, o_wa, e.waddr);
            end
        end
        $display("txn k=%0d op=%02h addr=%08h stall=%0d we=%0b wdata=%08h exc=%0b%0b",
                 k, v.op, v.addr, stall_n, o_we, o_wd, o_adel, o_ades);
        @(posedge clk); #1;
    endtask

    initial begin
        int t0;
        vec_t v;
        //            op       addr          sdata         rdata         we    wa     wdata         xwe   xwdata        xbe      xrdo          exc    stall
        vecs[0]  = mk(MEM_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b1, 5'd5,  32'h0,        1'b1, 32'hDEADBEEF, 4'b0000, 32'h0,        2'b00, 3);
        vecs[1]  = mk(MEM_LB,  32'h13, 32'h0,        32'h80123456, 1'b1, 5'd6,  32'h0,        1'b1, 32'hFFFFFF80, 4'b0111, 32'h0,        2'b00, 3);
        vecs[2]  = mk(MEM_LBU, 32'h13, 32'h0,        32'h80123456, 1'b1, 5'd7,  32'h0,        1'b1, 32'h00000080, 4'b0111, 32'h0,        2'b00, 3);
        vecs[3]  = mk(MEM_LH,  32'h02, 32'h0,        32'h80017FFF, 1'b1, 5'd8,  32'h0,        1'b1, 32'hFFFF8001, 4'b0011, 32'h0,        2'b00, 3);
        vecs[4]  = mk(MEM_LHU, 32'h00, 32'h0,        32'h8001ABCD, 1'b1, 5'd9,  32'h0,        1'b1, 32'h0000ABCD, 4'b1100, 32'h0,        2'b00, 3);
        vecs[5]  = mk(MEM_LB,  32'h00, 32'h0,        32'h1234567F, 1'b1, 5'd10, 32'h0,        1'b1, 32'h0000007F, 4'b1110, 32'h0,        2'b00, 3);
        vecs[6]  = mk(MEM_LB,  32'h01, 32'h0,        32'h1234C5AA, 1'b1, 5'd11, 32'h0,        1'b1, 32'hFFFFFFC5, 4'b1101, 32'h0,        2'b00, 3);
        vecs[7]  = mk(MEM_SH,  32'h02, 32'h1234ABCD, 32'h0,        1'b1, 5'd12, 32'h0,        1'b0, 32'h0,        4'b0011, 32'hABCDABCD, 2'b00, 3);
        vecs[8]  = mk(MEM_SB,  32'h05, 32'h000000A5, 32'h0,        1'b1, 5'd13, 32'h0,        1'b0, 32'h0,        4'b1101, 32'hA5A5A5A5, 2'b00, 3);
        vecs[9]  = mk(MEM_SW,  32'h08, 32'hCAFEF00D, 32'h0,        1'b1, 5'd14, 32'h0,        1'b0, 32'h0,        4'b0000, 32'hCAFEF00D, 2'b00, 3);
        vecs[10] = mk(MEM_LW,  32'h06, 32'h0,        32'h0,        1'b1, 5'd15, 32'h0,        1'b0, 32'h0,        4'hF,    32'h0,        2'b10, 0);
        vecs[11] = mk(MEM_SH,  32'h01, 32'h5555,     32'h0,        1'b1, 5'd16, 32'h0,        1'b0, 32'h0,        4'hF,    32'h0,        2'b01, 0);
        vecs[12] = mk(MEM_SW,  32'h02, 32'h5555,     32'h0,        1'b1, 5'd17, 32'h0,        1'b0, 32'h0,        4'hF,    32'h0,        2'b01, 0);
        vecs[13] = mk(MEM_LHU, 32'h03, 32'h0,        32'h0,        1'b1, 5'd18, 32'h0,        1'b0, 32'h0,        4'hF,    32'h0,        2'b10, 0);
        vecs[14] = mk(MEM_NOP, 32'h13, 32'h0,        32'h0,        1'b1, 5'd7,  32'h11223344, 1'b1, 32'h11223344, 4'hF,    32'h0,        2'b00, 0);
        vecs[15] = mk(8'h2A,   32'h03, 32'h0,        32'h0,        1'b1, 5'd2,  32'h00000055, 1'b1, 32'h00000055, 4'hF,    32'h0,        2'b00, 0);
        vecs[16] = mk(MEM_LH,  32'h04, 32'h0,        32'h00008000, 1'b1, 5'd19, 32'h0,        1'b1, 32'hFFFF8000, 4'b1100, 32'h0,        2'b00, 3);

        // Reset with live aligned ops on the inputs: every output must still show reset values.
        rst = 1'b1; rd0 = 32'h0;
        for (int k = 0; k < 2; k++) begin
            mem_op[k] = MEM_SW; mem_addr_i[k] = 32'h10; mem_data_i[k] = 32'hFFFF;
            we_i[k] = 1'b1; waddr_i[k] = 5'd3; wdata_i[k] = 32'h12345678;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("k%0d reset_outputs", k), pack_outs(k),
                {38'h0, 3'b000, 32'h0, 3'b111, 4'hF, 52'h0});
        @(posedge clk); #1;
        rst = 1'b0; set_nop(0); set_nop(1);
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) run_op(0, vecs[i]);
        set_nop(0);

        // WAIT_CYCLES=3: SW then LW back-to-back through the SRAM model.
        t0 = cyc;
        run_op(1, mk(MEM_SW, 32'h40, 32'hCAFE0001, 32'h0, 1'b1, 5'd4, 32'h0,
                     1'b0, 32'h0, 4'b0000, 32'hCAFE0001, 2'b00, 5));
        run_op(1, mk(MEM_LW, 32'h40, 32'h0, 32'h0, 1'b1, 5'd9, 32'h0,
                     1'b1, 32'hCAFE0001, 4'b0000, 32'h0, 2'b00, 5));
        chk("k1 back_to_back_cycles", cyc - t0, 12);

        // Reset in the 2nd ACCESS cycle of a store aborts it.
        mem_op[1] = MEM_SW; mem_addr_i[1] = 32'h44; mem_data_i[1] = 32'h0BADF00D;
        we_i[1] = 1'b0; waddr_i[1] = 5'd0; wdata_i[1] = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("k1 rst_pre_store_active", {ram_ce_n[1], ram_we_n[1], stall_o[1]}, 3'b001);
        rst = 1'b1;
        @(negedge clk);
        chk("k1 rst_cycle_outputs", pack_outs(1), {38'h0, 3'b000, 32'h0, 3'b111, 4'hF, 52'h0});
        @(posedge clk); #1;
        rst = 1'b0; set_nop(1);
        @(negedge clk);
        chk("k1 post_rst_idle", {ram_ce_n[1], ram_oe_n[1], ram_we_n[1], ram_be_n[1], stall_o[1]},
            {3'b111, 4'hF, 1'b0});
        @(posedge clk); #1;
        v = mk(MEM_LW, 32'h40, 32'h0, 32'h0, 1'b1, 5'd21, 32'h0,
               1'b1, 32'hCAFE0001, 4'b0000, 32'h0, 2'b00, 5);
        run_op(1, v);
        set_nop(1);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
